// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control sequencer.
//  - sw_state_e : FSM encoding, also the o_State output code seen by the datapath
//  - sw_ev_e    : decoded button event after priority resolution
//  - button slot indices for the debouncer array
//  - default timing constants (100 MHz system clock)
//  - cw()       : counter width helper, never narrower than 1 bit
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sw_state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_LONG,
    EV_SHORT,
    EV_START,
    EV_REC
  } sw_ev_e;

  localparam int NUM_BTN   = 3;
  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_REC   = 2;

  localparam int unsigned DEF_DEB_CNT   = 1_000_000;
  localparam int unsigned DEF_LONG_CNT  = 100_000_000;
  localparam int unsigned DEF_TICK_DIV  = 5_000_000;
  localparam int unsigned DEF_LAP_DEPTH = 4;
  localparam int unsigned DEF_LAP_AW    = 2;

  function automatic int unsigned cw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button / datapath-control bundle of the stopwatch sequencer.
//  i_fStart, i_fStop, i_fRecord : raw active-low buttons
//  o_Tick    : count enable       o_CntClr : clear running time
//  o_LapWr   : lap capture strobe o_LapIdx : lap write / view index
//  o_LapCnt  : valid laps         o_LapFull: all lap slots used
//  o_State   : 00 IDLE, 01 RUN, 10 PAUSE
// master = the sequencer, slave = datapath / button side.
interface stopwatch_ctrl_if #(
  parameter int LAP_AW = 2
) ();
  logic              i_fStart;
  logic              i_fStop;
  logic              i_fRecord;
  logic              o_Tick;
  logic              o_CntClr;
  logic              o_LapWr;
  logic [LAP_AW-1:0] o_LapIdx;
  logic [LAP_AW:0]   o_LapCnt;
  logic              o_LapFull;
  logic [1:0]        o_State;

  modport master (
    input  i_fStart, i_fStop, i_fRecord,
    output o_Tick, o_CntClr, o_LapWr, o_LapIdx, o_LapCnt, o_LapFull, o_State
  );

  modport slave (
    output i_fStart, i_fStop, i_fRecord,
    input  o_Tick, o_CntClr, o_LapWr, o_LapIdx, o_LapCnt, o_LapFull, o_State
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Per-button input conditioning: 2-FF synchroniser, then a debouncer that
// accepts the synced level once it has differed from the current debounced
// level for DEB_CNT consecutive cycles. Any return to the old level restarts
// the count. Edge pulses are registered and coincide with the level change.
//  i_Clk, i_Rst : clock, async active-high reset
//  i_Raw        : raw button (0 = pressed)
//  o_Level      : debounced level, 1 after reset
//  o_Fall/o_Rise: 1-cycle pulses on debounced 1->0 / 0->1
module btn_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CNT = DEF_DEB_CNT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Level,
  output logic o_Fall,
  output logic o_Rise
);
  localparam int unsigned CW = cw(DEB_CNT);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          synced;

  assign synced = sync_q[1];

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], i_Raw};
  end

  // Counter only runs while synced != level and is cleared on acceptance,
  // so it never exceeds DEB_CNT-1.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Level <= 1'b1;
      cnt_q   <= '0;
      o_Fall  <= 1'b0;
      o_Rise  <= 1'b0;
    end else begin
      o_Fall <= 1'b0;
      o_Rise <= 1'b0;
      if (synced == o_Level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CNT - 1)) begin
        cnt_q   <= '0;
        o_Level <= synced;
        o_Fall  <= ~synced;
        o_Rise  <= synced;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer. Debounces Start/Stop/Record, decodes
// press / short-release / long-press events and runs the IDLE/RUN/PAUSE FSM
// that drives the counting datapath and its lap registers.
//  i_Clk, i_Rst : clock, async active-high reset
//  sw (master)  : raw buttons in; tick, clear, lap strobe/index/count/full
//                 and state out
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CNT   = DEF_DEB_CNT,
  parameter int unsigned LONG_CNT  = DEF_LONG_CNT,
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned LAP_DEPTH = DEF_LAP_DEPTH,
  parameter int unsigned LAP_AW    = DEF_LAP_AW
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  stopwatch_ctrl_if.master sw
);
  localparam int unsigned PW  = cw(TICK_DIV);
  localparam int unsigned LCW = cw(LONG_CNT + 1);

  logic [NUM_BTN-1:0] raw, lvl, fall, rise;

  assign raw[BTN_START] = sw.i_fStart;
  assign raw[BTN_STOP]  = sw.i_fStop;
  assign raw[BTN_REC]   = sw.i_fRecord;

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb [NUM_BTN-1:0] (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Raw   (raw),
    .o_Level (lvl),
    .o_Fall  (fall),
    .o_Rise  (rise)
  );

  // Only Stop needs its level and release edge.
  logic unused_btn;
  assign unused_btn = ^{lvl[BTN_START], lvl[BTN_REC], rise[BTN_START], rise[BTN_REC]};

  // ---------------- long press ----------------
  // lcnt counts debounced-low cycles and saturates at LONG_CNT; reaching the
  // saturation value is itself the "long already fired" flag, still visible
  // in the release cycle because lcnt only clears once the level is high.
  logic [LCW-1:0] lcnt_q;
  logic           stop_long, stop_short;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)                          lcnt_q <= '0;
    else if (lvl[BTN_STOP])             lcnt_q <= '0;
    else if (lcnt_q != LCW'(LONG_CNT))  lcnt_q <= lcnt_q + 1'b1;
  end

  assign stop_long  = ~lvl[BTN_STOP] && (lcnt_q == LCW'(LONG_CNT - 1));
  assign stop_short = rise[BTN_STOP] && (lcnt_q != LCW'(LONG_CNT));

  sw_ev_e ev;
  always_comb begin
    ev = EV_NONE;
    if      (stop_long)       ev = EV_LONG;
    else if (stop_short)      ev = EV_SHORT;
    else if (fall[BTN_START]) ev = EV_START;
    else if (fall[BTN_REC])   ev = EV_REC;
  end

  // ---------------- FSM + prescaler + laps ----------------
  sw_state_e         state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [LAP_AW-1:0] idx_q, idx_d, idx_o;
  logic [LAP_AW:0]   cnt_q, cnt_d, idx_inc;
  logic              clr, wr;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign idx_inc = {1'b0, idx_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    idx_o   = idx_q;
    clr     = 1'b0;
    wr      = 1'b0;

    case (state_q)
      ST_RUN:   presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + 1'b1;
      ST_PAUSE: presc_d = presc_q;
      default:  presc_d = '0;
    endcase

    case (ev)
      EV_LONG: begin
        state_d = ST_IDLE;
        clr     = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        presc_d = '0;
      end
      EV_SHORT: begin
        if (state_q != ST_IDLE) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end
      end
      EV_START: begin
        state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
      EV_REC: begin
        if (state_q == ST_RUN) begin
          // Write index is presented combinationally in the strobe cycle
          // and held afterwards so the display shows the fresh lap.
          if (cnt_q < (LAP_AW+1)'(LAP_DEPTH)) begin
            wr    = 1'b1;
            idx_o = cnt_q[LAP_AW-1:0];
            idx_d = cnt_q[LAP_AW-1:0];
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == '0) begin
          idx_d = '0;
        end else begin
          idx_d = (idx_inc >= cnt_q) ? '0 : idx_inc[LAP_AW-1:0];
        end
      end
      default: ;
    endcase
  end

  assign sw.o_Tick    = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign sw.o_CntClr  = clr;
  assign sw.o_LapWr   = wr;
  assign sw.o_LapIdx  = idx_o;
  assign sw.o_LapCnt  = cnt_q;
  assign sw.o_LapFull = (cnt_q == (LAP_AW+1)'(LAP_DEPTH));
  assign sw.o_State   = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  localparam int DEB = 4, LONG = 20, TDIV = 5, DEPTH = 4, AW = 2;
  localparam int K_NONE = 0, K_ST = 1, K_CLR = 2, K_WR = 3;

  typedef struct { int kind; int val; } sb_t;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  int   vectors = 0, miscompares = 0;
  sb_t  sb[$];
  int   mstate = 0, mcnt = 0, midx = 0;
  int   run_cyc = 0;
  logic [1:0] prev_st = 2'b00;

  stopwatch_ctrl_if #(.LAP_AW(AW)) sw ();

  stopwatch_ctrl #(
    .DEB_CNT(DEB), .LONG_CNT(LONG), .TICK_DIV(TDIV), .LAP_DEPTH(DEPTH), .LAP_AW(AW)
  ) dut (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .sw    (sw)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int val);
    sb_t e;
    e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input string tag, input int kind, input int val);
    sb_t e;
    if (sb.size() == 0) begin e.kind = K_NONE; e.val = 0; end
    else e = sb.pop_front();
    chk({tag, "_kind"}, kind, e.kind);
    chk({tag, "_val"}, val, e.val);
  endtask

  // Monitor: pops scoreboard on every observable datapath event and checks
  // tick spacing against the number of RUN cycles since the last tick.
  always @(negedge i_Clk) begin
    if (i_Rst) begin
      run_cyc = 0;
    end else begin
      if (sw.o_CntClr) sb_pop("clr", K_CLR, int'(sw.o_State));
      if (sw.o_LapWr)  sb_pop("wr", K_WR, int'(sw.o_LapIdx));
      if (sw.o_State != prev_st) sb_pop("state", K_ST, int'(sw.o_State));
      if (sw.o_State == 2'b01) begin
        run_cyc++;
        chk("tick", sw.o_Tick, run_cyc == TDIV);
        if (run_cyc == TDIV) run_cyc = 0;
      end else begin
        if (sw.o_State == 2'b00) run_cyc = 0;
        if (sw.o_Tick) chk("tick_stopped", sw.o_Tick, 1'b0);
      end
    end
    prev_st = sw.o_State;
  end

  // ---- event-level reference model ----
  task automatic m_start();
    mstate = (mstate == 1) ? 2 : 1;
    push(K_ST, mstate);
  endtask

  task automatic m_rec();
    if (mstate == 1) begin
      if (mcnt < DEPTH) begin
        push(K_WR, mcnt);
        midx = mcnt;
        mcnt++;
      end
    end else begin
      midx = (mcnt == 0) ? 0 : (midx + 1) % mcnt;
    end
  endtask

  task automatic m_short();
    if (mstate != 0) begin
      push(K_CLR, mstate);
      push(K_ST, 0);
    end
    mstate = 0;
  endtask

  task automatic m_long();
    push(K_CLR, mstate);
    if (mstate != 0) push(K_ST, 0);
    mstate = 0; mcnt = 0; midx = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_state"}, sw.o_State, mstate);
    chk({tag, "_lapcnt"}, sw.o_LapCnt, mcnt);
    chk({tag, "_lapidx"}, sw.o_LapIdx, midx);
    chk({tag, "_full"}, sw.o_LapFull, mcnt == DEPTH);
  endtask

  // b: 0 start, 1 stop, 2 record
  task automatic press(input int b, input int len);
    @(negedge i_Clk);
    case (b)
      0: sw.i_fStart = 1'b0;
      1: sw.i_fStop = 1'b0;
      default: sw.i_fRecord = 1'b0;
    endcase
    repeat (len) @(negedge i_Clk);
    sw.i_fStart = 1'b1; sw.i_fStop = 1'b1; sw.i_fRecord = 1'b1;
    repeat (14) @(negedge i_Clk);
  endtask

  initial begin
    sw.i_fStart = 1'b1; sw.i_fStop = 1'b1; sw.i_fRecord = 1'b1;
    repeat (3) @(negedge i_Clk);
    chk("rst_state", sw.o_State, 0);
    chk("rst_tick", sw.o_Tick, 0);
    chk("rst_clr", sw.o_CntClr, 0);
    chk("rst_wr", sw.o_LapWr, 0);
    i_Rst = 1'b0;
    repeat (2) @(negedge i_Clk);
    chk_regs("post_rst");

    // bounce: too short to be accepted
    press(0, 2);
    chk_regs("bounce");

    // start, then run long enough for several ticks
    m_start(); press(0, 10);
    repeat (11) @(negedge i_Clk);
    chk_regs("run");

    // pause mid-period, idle a while, resume
    m_start(); press(0, 6);
    repeat (7) @(negedge i_Clk);
    chk_regs("pause");
    m_start(); press(0, 6);

    // five records in RUN: last one hits a full lap store
    for (int i = 0; i < 5; i++) begin
      m_rec(); press(2, 5);
    end
    chk_regs("laps_full");

    // long stop press
    m_long(); press(1, 30);
    chk_regs("long");

    // record in IDLE with no laps
    m_rec(); press(2, 5);
    chk_regs("browse_empty");

    // three laps then browse in PAUSE
    m_start(); press(0, 5);
    for (int i = 0; i < 3; i++) begin
      m_rec(); press(2, 5);
    end
    m_start(); press(0, 5);
    for (int i = 0; i < 5; i++) begin
      m_rec(); press(2, 5);
      chk_regs("browse");
    end

    // short stop from RUN keeps laps
    m_start(); press(0, 5);
    m_short(); press(1, 8);
    chk_regs("short");

    // Stop release and Start press debounce in the same cycle
    m_start(); press(0, 5);
    m_short();
    @(negedge i_Clk);
    sw.i_fStop = 1'b0;
    repeat (8) @(negedge i_Clk);
    sw.i_fStop = 1'b1; sw.i_fStart = 1'b0;
    repeat (8) @(negedge i_Clk);
    sw.i_fStart = 1'b1;
    repeat (14) @(negedge i_Clk);
    chk_regs("coincide");

    // async reset mid-RUN
    m_start(); press(0, 5);
    chk_regs("pre_rst");
    @(posedge i_Clk);
    #2 i_Rst = 1'b1;
    #1;
    mstate = 0; mcnt = 0; midx = 0;
    chk_regs("async_rst");
    chk("async_rst_tick", sw.o_Tick, 0);
    chk("async_rst_clr", sw.o_CntClr, 0);
    chk("async_rst_wr", sw.o_LapWr, 0);
    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    repeat (5) @(negedge i_Clk);

    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
